// File: rtl/exec_wb_sender.sv
// exec_wb_sender
//   Result queue between the execute stage and writeback. Results enter on a
//   valid/ready handshake from execute. They leave in arrival order on a
//   valid/ready handshake to writeback. While a result is waiting, execute can
//   look up its destination tag to forward the value early.
//
//   Optional feature (macro EXEC_WB_SENDER_BYPASS_EN):
//     When the queue is empty, the execute result is presented on wb_* in the
//     same cycle. If writeback takes it, the result is never queued.
//
// Parameters
//   DATA_W  result data width
//   TAG_W   destination register tag width
//   DEPTH   queue depth, power of two in 2..16
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   ex_valid/ex_ready  input handshake (ex_data, ex_tag)
//   wb_valid/wb_ready  output handshake (wb_data, wb_tag = head entry)
//   count              number of queued entries
//   fwd_tag            forwarding lookup tag
//   fwd_hit/fwd_data   youngest queued entry matching fwd_tag (0 when none)
module exec_wb_sender #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [DATA_W-1:0]        ex_data,
  input  logic [TAG_W-1:0]         ex_tag,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [TAG_W-1:0]         fwd_tag,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Storage is not reset: only pointers and count are. The output muxes
  // force zeros whenever the queue is empty.
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          q_valid;
  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  assign q_valid = (count != '0);
  assign full    = (count == CW'(DEPTH));

  // When the queue is full, a pop in the same cycle frees the slot. The
  // write lands in the slot being read out, and that slot's read is
  // combinational.
  assign ex_ready = !rst && (!full || wb_ready);
  assign pop      = !rst && q_valid && wb_ready;

`ifdef EXEC_WB_SENDER_BYPASS_EN
  logic byp;

  assign byp      = !rst && !q_valid && ex_valid;
  assign wb_valid = q_valid || byp;
  assign wb_data  = q_valid ? data_mem[rd_ptr] : (byp ? ex_data : '0);
  assign wb_tag   = q_valid ? tag_mem[rd_ptr]  : (byp ? ex_tag  : '0);
  // A bypassed result that writeback takes this cycle is never queued.
  assign push     = ex_valid && ex_ready && !(byp && wb_ready);
`else
  assign wb_valid = q_valid;
  assign wb_data  = q_valid ? data_mem[rd_ptr] : '0;
  assign wb_tag   = q_valid ? tag_mem[rd_ptr]  : '0;
  assign push     = ex_valid && ex_ready;
`endif

  // Pointers wrap naturally because DEPTH is a power of two. Empty and full
  // are told apart by count only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= ex_data;
      tag_mem[wr_ptr]  <= ex_tag;
    end
  end

  // Scan from oldest to youngest so that a later match overrides an earlier
  // one. Only the entries queued before this edge are scanned: an entry
  // being pushed now is not yet counted, and an entry being popped now still is.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (tag_mem[fwd_idx] == fwd_tag)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_sender.sv
module tb_exec_wb_sender;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_data;
  logic [TAG_W-1:0]  ex_tag;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic [2:0]        count;
  logic [TAG_W-1:0]  fwd_tag;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int checks = 0;
  int errors = 0;

  exec_wb_sender #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data), .ex_tag(ex_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .count(count), .fwd_tag(fwd_tag), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic              ev;
    logic [TAG_W-1:0]  etag;
    logic [DATA_W-1:0] edata;
    logic              wr;
    logic [TAG_W-1:0]  ftag;
    logic              x_rdy;
    logic              x_wv;
    logic [2:0]        x_cnt;
    logic [TAG_W-1:0]  x_tag;
    logic [DATA_W-1:0] x_data;
    logic              x_hit;
    logic [DATA_W-1:0] x_fdata;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  vec_t vecs[12];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_data = '0; ex_tag = '0; wb_ready = 1'b0; fwd_tag = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_ex_ready_low", ex_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ex_ready_high", ex_ready, 1);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", wb_tag, 0);
  endtask

  task automatic push_one(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    ex_valid = 1'b1; ex_tag = t; ex_data = d; wb_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] c0_data;
    logic [TAG_W-1:0]  c0_tag;
    logic              c0_wv;
    int pops;

`ifdef EXEC_WB_SENDER_BYPASS_EN
    c0_wv = 1'b1; c0_tag = 5'd1; c0_data = 32'h11;
`else
    c0_wv = 1'b0; c0_tag = 5'd0; c0_data = 32'h0;
`endif
    //          ev etag  edata  wr ftag rdy wv cnt tag   data   hit fdata
    vecs[0]  = '{1, 5'd1, 32'h11, 0, 5'd1, 1, c0_wv, 3'd0, c0_tag, c0_data, 0, 32'h0};
    vecs[1]  = '{1, 5'd2, 32'h22, 0, 5'd1, 1, 1, 3'd1, 5'd1, 32'h11, 1, 32'h11};
    vecs[2]  = '{1, 5'd3, 32'h33, 0, 5'd2, 1, 1, 3'd2, 5'd1, 32'h11, 1, 32'h22};
    vecs[3]  = '{1, 5'd4, 32'h44, 0, 5'd3, 1, 1, 3'd3, 5'd1, 32'h11, 1, 32'h33};
    vecs[4]  = '{1, 5'd9, 32'h99, 0, 5'd4, 0, 1, 3'd4, 5'd1, 32'h11, 1, 32'h44};
    vecs[5]  = '{0, 5'd0, 32'h0,  0, 5'd9, 0, 1, 3'd4, 5'd1, 32'h11, 0, 32'h0};
    vecs[6]  = '{1, 5'd5, 32'h55, 1, 5'd1, 1, 1, 3'd4, 5'd1, 32'h11, 1, 32'h11};
    vecs[7]  = '{0, 5'd0, 32'h0,  1, 5'd5, 1, 1, 3'd4, 5'd2, 32'h22, 1, 32'h55};
    vecs[8]  = '{0, 5'd0, 32'h0,  1, 5'd1, 1, 1, 3'd3, 5'd3, 32'h33, 0, 32'h0};
    vecs[9]  = '{0, 5'd0, 32'h0,  1, 5'd4, 1, 1, 3'd2, 5'd4, 32'h44, 1, 32'h44};
    vecs[10] = '{0, 5'd0, 32'h0,  1, 5'd5, 1, 1, 3'd1, 5'd5, 32'h55, 1, 32'h55};
    vecs[11] = '{0, 5'd0, 32'h0,  0, 5'd5, 1, 0, 3'd0, 5'd0, 32'h0,  0, 32'h0};

    rst = 1'b1;
    idle_inputs();
    tick();
    do_reset();

    // Fill, hold while full, push+pop at full, then drain in order.
    for (int i = 0; i < 12; i++) begin
      ex_valid = vecs[i].ev; ex_tag = vecs[i].etag; ex_data = vecs[i].edata;
      wb_ready = vecs[i].wr; fwd_tag = vecs[i].ftag;
      #1;
      chk($sformatf("v%0d_ex_ready", i), ex_ready, vecs[i].x_rdy);
      chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].x_wv);
      chk($sformatf("v%0d_count", i), count, vecs[i].x_cnt);
      chk($sformatf("v%0d_wb_tag", i), wb_tag, vecs[i].x_tag);
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].x_data);
      chk($sformatf("v%0d_fwd_hit", i), fwd_hit, vecs[i].x_hit);
      chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].x_fdata);
      tick();
    end

    // Two entries with the same tag: the youngest wins.
    do_reset();
    push_one(5'd7, 32'hA);
    push_one(5'd7, 32'hB);
    fwd_tag = 5'd7;
    #1;
    chk("fwd_dup_count", count, 2);
    chk("fwd_dup_hit", fwd_hit, 1);
    chk("fwd_dup_data", fwd_data, 32'hB);
    fwd_tag = 5'd9;
    #1;
    chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);

    // Reset mid-operation together with an offered push.
    do_reset();
    push_one(5'd1, 32'h1);
    push_one(5'd2, 32'h2);
    push_one(5'd3, 32'h3);
    rst = 1'b1; ex_valid = 1'b1; ex_tag = 5'd6; ex_data = 32'h66; fwd_tag = 5'd6;
    #1;
    chk("midrst_count_before", count, 3);
    chk("midrst_ex_ready", ex_ready, 0);
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_fwd_hit", fwd_hit, 0);
    chk("midrst_ex_ready", ex_ready, 1);

    // Empty queue, push and ready in the same cycle.
    do_reset();
    ex_valid = 1'b1; ex_tag = 5'd3; ex_data = 32'h3; wb_ready = 1'b1;
    #1;
`ifdef EXEC_WB_SENDER_BYPASS_EN
    chk("byp_wb_valid", wb_valid, 1);
    chk("byp_wb_tag", wb_tag, 3);
`else
    chk("byp_wb_valid", wb_valid, 0);
`endif
    tick();
    ex_valid = 1'b0; wb_ready = 1'b0;
    #1;
`ifdef EXEC_WB_SENDER_BYPASS_EN
    chk("byp_next_count", count, 0);
    chk("byp_next_wb_valid", wb_valid, 0);
`else
    chk("byp_next_count", count, 1);
    chk("byp_next_wb_valid", wb_valid, 1);
    chk("byp_next_wb_tag", wb_tag, 3);
`endif

    // Random traffic against a queue reference model.
    do_reset();
    mq.delete();
    pops = 0;
    for (int n = 0; n < 10000; n++) begin
      logic exp_rdy, exp_wv, byp_now, do_push, do_pop, exp_hit;
      logic [DATA_W-1:0] exp_fd;
      ent_t head;
      ex_valid = 1'($urandom % 2);
      ex_tag   = TAG_W'($urandom_range(0, 7));
      ex_data  = $urandom;
      wb_ready = 1'($urandom % 2);
      fwd_tag  = TAG_W'($urandom_range(0, 7));
      #1;
      exp_rdy = (mq.size() < DEPTH) || wb_ready;
`ifdef EXEC_WB_SENDER_BYPASS_EN
      byp_now = (mq.size() == 0) && ex_valid;
`else
      byp_now = 1'b0;
`endif
      exp_wv = (mq.size() > 0) || byp_now;
      if (mq.size() > 0) head = mq[0];
      else begin head.tag = ex_tag; head.data = ex_data; end
      exp_hit = 1'b0; exp_fd = '0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (mq[k].tag == fwd_tag) begin exp_hit = 1'b1; exp_fd = mq[k].data; break; end
      end
      chk("rnd_count", count, mq.size());
      chk("rnd_ex_ready", ex_ready, exp_rdy);
      chk("rnd_wb_valid", wb_valid, exp_wv);
      chk("rnd_fwd_hit", fwd_hit, exp_hit);
      chk("rnd_fwd_data", fwd_data, exp_fd);
      if (exp_wv) begin
        chk("rnd_wb_tag", wb_tag, head.tag);
        chk("rnd_wb_data", wb_data, head.data);
      end
      do_push = ex_valid && exp_rdy && !(byp_now && wb_ready);
      do_pop  = (mq.size() > 0) && wb_ready;
      begin
        ent_t e;
        e.tag = ex_tag; e.data = ex_data;
        tick();
        if (do_pop) begin void'(mq.pop_front()); pops++; end
        if (do_push) mq.push_back(e);
      end
    end
    chk("rnd_pointer_wraps", (pops >= 20 * DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_wb_sender.md
EXEC_WB_SENDER -- requirements
Module: exec_wb_sender

Interface
REQ-001 Parameter DATA_W, default 32: result data width in bits.
REQ-002 Parameter TAG_W, default 5: destination register tag width in bits.
REQ-003 Parameter DEPTH, default 4: result queue depth; SHALL be a power of two, 2..16.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ex_valid  input  1  execute stage offers a result.
REQ-007 ex_ready  output  1  sender accepts the result this cycle.
REQ-008 ex_data  input  DATA_W  result value.
REQ-009 ex_tag  input  TAG_W  destination tag.
REQ-010 wb_valid  output  1  result presented to writeback.
REQ-011 wb_ready  input  1  writeback consumes the result this cycle.
REQ-012 wb_data  output  DATA_W  head result value.
REQ-013 wb_tag  output  TAG_W  head destination tag.
REQ-014 count  output  clog2(DEPTH)+1  number of queued entries.
REQ-015 fwd_tag  input  TAG_W  forwarding lookup tag from execute.
REQ-016 fwd_hit  output  1  a queued entry matches fwd_tag.
REQ-017 fwd_data  output  DATA_W  data of the youngest matching queued entry.

Function
REQ-018 Input transfer occurs when ex_valid and ex_ready are both high on a rising edge; output transfer occurs when wb_valid and wb_ready are both high.
REQ-019 ex_ready SHALL be high when count < DEPTH, or when count == DEPTH and wb_ready is high (pop frees a slot in the same cycle).
REQ-020 wb_valid SHALL be high exactly when count > 0 (without bypass); wb_valid SHALL NOT depend combinationally on wb_ready.
REQ-021 Queued data SHALL leave in strict arrival order; latency from input transfer to wb_valid is 1 cycle when the queue is empty.
REQ-022 A simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH and at count == 1.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by count, not by pointer equality.
REQ-024 wb_data and wb_tag SHALL hold stable while wb_valid is high and wb_ready is low.
REQ-025 A push while full without a same-cycle pop SHALL NOT occur (ex_ready low); ex_valid during that cycle SHALL be ignored.
REQ-026 fwd_hit/fwd_data SHALL be combinational over the currently queued entries; with multiple matches, the youngest entry wins; with no match, fwd_hit is 0 and fwd_data is 0.
REQ-027 An entry popped in the current cycle SHALL still be visible to forwarding in that cycle; an entry pushed in the current cycle SHALL NOT be.

Reset
REQ-028 When rst is high at a rising edge: count = 0, both pointers = 0, wb_valid = 0, fwd_hit = 0, wb_data = 0, wb_tag = 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries; a handshake in the same cycle as reset SHALL be ignored.
REQ-030 ex_ready SHALL be 0 while rst is high and 1 on the first cycle after reset.

Configuration
REQ-031 Macro EXEC_WB_SENDER_BYPASS_EN compiles in the empty-queue bypass.
REQ-032 With the macro defined: when count == 0 and ex_valid is high, wb_valid is high in the same cycle with wb_data/wb_tag = ex_data/ex_tag; if wb_ready is also high, the result is transferred and not queued (zero latency).
REQ-033 Without the macro: no combinational path from ex_* to wb_*; REQ-020 and REQ-021 apply unchanged.

Verification
REQ-034 Reset, then push tags 1,2,3,4 (data 0x11..0x44) with wb_ready=0 -> count=4, ex_ready=0, wb_tag=1 held stable.
REQ-035 Full queue, ex_valid=1 tag 5 and wb_ready=1 same cycle -> tag 1 popped, tag 5 accepted, count stays 4; subsequent output order 2,3,4,5.
REQ-036 Queue holds tag 7 data 0xA then tag 7 data 0xB; fwd_tag=7 -> fwd_hit=1, fwd_data=0xB; fwd_tag=9 -> fwd_hit=0, fwd_data=0.
REQ-037 Push 3 entries, assert rst for one cycle alongside ex_valid=1 -> count=0, wb_valid=0 next cycle, new entry discarded.
REQ-038 Random ex_valid/wb_ready at 50% over 10000 cycles, >=20 pointer wraps -> output stream equals input stream, no loss or duplication.
REQ-039 With EXEC_WB_SENDER_BYPASS_EN, empty queue, ex_valid=1 tag 3 and wb_ready=1 -> wb_valid=1, wb_tag=3 same cycle, count remains 0; without the macro -> wb_valid=0 that cycle, 1 the next.
